// File: rtl/usb_sample_fifo.sv
// First-word-fall-through byte FIFO between ADC capture and the USB write stage, with drop
// accounting. Optional block-average decimation is enabled by defining USB_FIFO_DECIM_EN.
module usb_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned DECIM_LOG2 = 2
) (
    input  logic                  clk_usb,
    input  logic                  en,
    input  logic [7:0]            sample_in,
    input  logic                  sample_stb,
    input  logic                  out_rd,
    input  logic                  clr_ovf,
    output logic [7:0]            data_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  prod_vld;
    logic [7:0]            prod_data;
    logic                  rd_en, wr_en, drop;

`ifdef USB_FIFO_DECIM_EN
    localparam int unsigned AccW = 8 + DECIM_LOG2;

    logic signed [AccW-1:0]  acc_q, acc_d, acc_sum;
    logic [DECIM_LOG2-1:0]   phase_q, phase_d;

    always_comb begin
        acc_sum   = acc_q + $signed({{DECIM_LOG2{sample_in[7]}}, sample_in});
        acc_d     = acc_q;
        phase_d   = phase_q;
        prod_vld  = 1'b0;
        // Arithmetic shift floors the mean of the group.
        prod_data = 8'(acc_sum >>> DECIM_LOG2);
        if (sample_stb) begin
            if (phase_q == '1) begin
                prod_vld = 1'b1;
                acc_d    = '0;
                phase_d  = '0;
            end else begin
                acc_d    = acc_sum;
                phase_d  = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_usb or negedge en) begin
        if (!en) begin
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end
`else
    assign prod_vld  = sample_stb;
    assign prod_data = sample_in;
`endif

    // A read frees a slot in the same cycle, so a full FIFO still accepts a word alongside it.
    assign rd_en = out_rd & ~empty_q;
    assign wr_en = prod_vld & (~full_q | rd_en);
    assign drop  = prod_vld & full_q & ~rd_en;

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        empty_d    = (level_d == '0);
        full_d     = (level_d == LevelFull);
        ovf_d      = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk_usb or negedge en) begin
        if (!en) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: empty gates data_out and pointers are reset.
    always_ff @(posedge clk_usb) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= prod_data;
        end
    end

    assign data_out = empty_q ? 8'd0 : mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule
